// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// if_fetch_unit_pkg : shared types and PC helpers for the IF fetch stage
// Revision : 1.0
// ============================================================================
package if_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEFAULT_BUF_DEPTH = 2;

  typedef enum logic [0:0] {
    IF_RUN   = 1'b0,
    IF_DRAIN = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Wraps naturally at 32 bits: 32'hFFFF_FFFC -> 32'h0000_0000.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return align_pc(pc) + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_buffer.sv
`default_nettype none
// ============================================================================
// if_fetch_unit_fetch_buffer : small circular FIFO, flush beats push and pop
// Revision : 1.0
// ============================================================================
module if_fetch_unit_fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_en = push && !flush && (count_q != FULL);
  assign pop_en  = pop && !flush && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
      else if (!push_en && pop_en) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push_en) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// if_fetch_unit : RV32I IF stage - PC, credit-limited imem fetch, redirect drain
// Revision : 1.0
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
);

  localparam int unsigned      CNT_W        = $clog2(BUF_DEPTH + 1);
  localparam int unsigned      SUM_W        = CNT_W + 1;
  localparam int unsigned      ENTRY_W      = $bits(fetch_entry_t);
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(BUF_DEPTH);
  localparam logic [31:0]      RESET_PC_AL  = align_pc(RESET_PC);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  if_state_e        state_q, state_d;

  logic [CNT_W-1:0] outstanding;
  logic [31:0]      tag_head;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     push_entry;

  logic             credit_ok;
  logic             req_fire;
  logic             resp_accept;
  logic             buf_push;
  logic             buf_flush;
  logic             id_pop;
  logic             head_valid;

  // The tag queue occupancy is the in-flight request count; it is popped by
  // every accepted response, including the ones discarded while draining.
  if_fetch_unit_fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (32),
    .CNT_W (CNT_W)
  ) u_tag_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_accept),
    .flush     (1'b0),
    .count     (outstanding),
    .head      (tag_head)
  );

  if_fetch_unit_fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (id_pop),
    .flush     (buf_flush),
    .count     (buf_count),
    .head      (buf_head)
  );

  // Same-cycle pops give no credit, so every response has a reserved slot.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, buf_count}) < CREDIT_LIMIT;
  assign imem_req_valid = !rst && (state_q == IF_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_accept    = imem_resp_valid && (outstanding != '0);

  assign head_valid     = buf_count != '0;
  assign id_pop         = head_valid && !stall_id && !redirect_valid;
  assign push_entry     = '{pc: tag_head, inst: imem_resp_data};

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;
    buf_push   = 1'b0;
    buf_flush  = 1'b0;
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      drop_cnt_d = outstanding - CNT_W'(resp_accept);
      buf_flush  = 1'b1;
      state_d    = (drop_cnt_d != '0) ? IF_DRAIN : IF_RUN;
    end else begin
      if (req_fire) pc_d = next_pc(pc_q);
      if (resp_accept) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        else                  buf_push   = 1'b1;
      end
      if ((state_q == IF_DRAIN) && (drop_cnt_d == '0)) state_d = IF_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC_AL;
      drop_cnt_q <= '0;
      state_q    <= IF_RUN;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  assign if_id_valid = !rst && head_valid;
  assign if_id_inst  = buf_head.inst;
  assign if_id_pc    = buf_head.pc;
  assign if_id_pc4   = next_pc(buf_head.pc);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_if_fetch_unit : randomized scoreboard bench for if_fetch_unit
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_id = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_id(stall_id),
    .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;

  pend_t       pend[$];      // imem model: requests awaiting a response
  logic [31:0] exp_q[$];     // scoreboard: correct-path PCs ID has yet to take
  logic [31:0] req_exp = RESET_PC;
  int checks = 0, errors = 0, cyc = 0, last_due = 0, consumed = 0;
  int first_fire_cyc = -1, first_valid_cyc = -1, phase = 0;
  int ready_pct = 100, stall_pct = 0, lat_min = 1, lat_max = 1, redir_permil = 0;
  bit rst_req = 1'b1, redir_req = 1'b0, redir_on_resp = 1'b0, redir_done = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver and imem model: one call per clock cycle, inputs change at negedge.
  task automatic do_cycle();
    bit stale_seen;
    int lat, due;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    if (rst_req) begin
      pend.delete(); exp_q.delete();
      req_exp = RESET_PC; last_due = 0;
      first_fire_cyc = -1; first_valid_cyc = -1;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
      redirect_valid = 1'b0; stall_id = 1'b0;
      return;
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    stall_id       = ($urandom_range(99) < stall_pct);
    stale_seen = 1'b0;
    foreach (pend[i]) if (pend[i].stale) stale_seen = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    if (redir_on_resp && imem_resp_valid) begin
      redir_on_resp = 1'b0; redir_req = 1'b1; redir_done = 1'b1;
    end
    if (!redir_req && ($urandom_range(999) < redir_permil)) begin
      redir_req = 1'b1;
      redir_target = $urandom & 32'h0000_3FFF;
    end
    redirect_valid = 1'b0;
    if (redir_req) begin
      redir_req = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = redir_target;
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_q.delete();
      req_exp = redir_target & ~32'h3;
    end
    #1;
    if (redirect_valid || stale_seen) chk("no_req_redirect_or_drain", imem_req_valid, 0);
    if (imem_req_valid) chk("req_addr", imem_req_addr, req_exp);
    if (imem_req_valid && imem_req_ready) begin
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      pend.push_back('{req_exp, due, 1'b0});
      exp_q.push_back(req_exp);
      req_exp = req_exp + 32'd4;
      chk("credit_cap", exp_q.size() <= BUF_DEPTH, 1);
    end
  endtask

  // Monitor: compares the presented head against the scoreboard each cycle.
  initial begin
    bit prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_id_valid", if_id_valid, 0);
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("stall_hold_valid", if_id_valid, 1);
        if (if_id_valid && first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          if (phase == 1) chk("first_latency", cyc - first_fire_cyc, 2);
        end
        if (if_id_valid && !redirect_valid) begin
          chk("head_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("if_id_pc", if_id_pc, exp_q[0]);
            chk("if_id_inst", if_id_inst, mem_word(exp_q[0]));
            chk("if_id_pc4", if_id_pc4, exp_q[0] + 32'd4);
            if (!stall_id) begin
              void'(exp_q.pop_front());
              consumed++;
            end
          end
        end
        prev_hold = if_id_valid && stall_id && !redirect_valid;
      end
    end
  end

  task automatic wait_inflight2(input string name);
    int n = 0;
    while (!(pend.size() == 2 && !pend[0].stale) && n < 60) begin
      do_cycle();
      n++;
    end
    chk(name, n < 60, 1);
  endtask

  initial begin
    phase = 1;
    repeat (3) do_cycle();
    rst_req = 1'b0;
    repeat (20) do_cycle();

    phase = 2;
    stall_pct = 100; repeat (5) do_cycle();
    stall_pct = 0;   repeat (8) do_cycle();
    ready_pct = 0;   repeat (3) do_cycle();
    ready_pct = 100; repeat (8) do_cycle();

    lat_min = 3; lat_max = 4;
    wait_inflight2("reach_two_inflight");
    redir_target = 32'h0000_0100; redir_req = 1'b1;
    repeat (20) do_cycle();

    wait_inflight2("reach_two_inflight_drain");
    redir_target = 32'h0000_0180; redir_req = 1'b1; do_cycle();
    redir_target = 32'h0000_0200; redir_req = 1'b1;
    repeat (20) do_cycle();

    lat_min = 1; lat_max = 3;
    redir_target = 32'h0000_0302; redir_on_resp = 1'b1; redir_done = 1'b0;
    for (int i = 0; i < 40 && !redir_done; i++) do_cycle();
    chk("redirect_with_resp", redir_done, 1);
    redir_on_resp = 1'b0;
    repeat (15) do_cycle();

    redir_target = 32'hFFFF_FFF8; redir_req = 1'b1;
    repeat (20) do_cycle();

    rst_req = 1'b1; repeat (2) do_cycle();
    rst_req = 1'b0; repeat (15) do_cycle();

    phase = 3;
    ready_pct = 70; stall_pct = 30; lat_min = 1; lat_max = 4; redir_permil = 30;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(999) < 2);
      do_cycle();
    end
    rst_req = 1'b0; redir_permil = 0;
    repeat (20) do_cycle();
    chk("forward_progress", consumed > 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
